mmio_bus_switch: RTL and testbench

//  Parametrised memory-mapped bus switch between the CPU data port and NREG peripheral windows plus one

---
 rtl/mmio_bus_switch_pkg.sv | 20 ++
 rtl/mmio_bus_switch_addr_decode.sv | 43 ++++
 rtl/mmio_bus_switch.sv | 180 ++++++++++++++++++
 tb/tb_mmio_bus_switch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bus_switch_pkg.sv
// Shared definitions for the MMIO bus switch: FSM state codes, error-data fill
// and the default-slave index helper.
package mmio_bus_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } bus_state_e;

    // Fill bit replicated across m_rdata when a read is aborted.
    localparam logic ERR_FILL = 1'b1;

    // The default slave (SDRAM) sits one past the last mapped window.
    function automatic int default_slave(input int nreg);
        return nreg;
    endfunction

endpackage

// File: rtl/mmio_bus_switch_addr_decode.sv
// Combinational window matcher: lowest matching window wins, instruction
// fetches and misses go to the default slave with the address unmodified.
module mmio_addr_decode
    import mmio_bus_switch_pkg::*;
#(
    parameter int                       ADDR_W       = 16,
    parameter int                       NREG         = 4,
    parameter logic [NREG*ADDR_W-1:0]   REGION_BASE  = '0,
    parameter logic [NREG*ADDR_W-1:0]   REGION_LIMIT = '0,
    parameter logic [NREG-1:0]          REGION_WO    = '0
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              instr_i,
    output logic [NREG:0]     sel_o,
    output logic [ADDR_W-1:0] offset_o,
    output logic              wo_o
);

    logic hit;

    always_comb begin
        sel_o    = '0;
        offset_o = addr_i;
        wo_o     = 1'b0;
        hit      = 1'b0;
        if (!instr_i) begin
            for (int i = 0; i < NREG; i++) begin
                if (!hit &&
                    addr_i >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
                    addr_i <= REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
                    hit      = 1'b1;
                    sel_o[i] = 1'b1;
                    offset_o = addr_i - REGION_BASE[i*ADDR_W +: ADDR_W];
                    wo_o     = REGION_WO[i];
                end
            end
        end
        if (!hit) begin
            sel_o[default_slave(NREG)] = 1'b1;
        end
    end

endmodule

// File: rtl/mmio_bus_switch.sv
// Memory-mapped bus switch: CPU data port to NREG windows plus a default slave.
// Define BUS_TIMEOUT_EN to abort transactions after TIMEOUT cycles without s_ready.
module mmio_bus_switch
    import mmio_bus_switch_pkg::*;
#(
    parameter int                       ADDR_W       = 16,
    parameter int                       DATA_W       = 16,
    parameter int                       NREG         = 4,
    parameter logic [NREG*ADDR_W-1:0]   REGION_BASE  = {16'h1000, 16'h0002, 16'h0001, 16'h0000},
    parameter logic [NREG*ADDR_W-1:0]   REGION_LIMIT = {16'h4BFF, 16'h0002, 16'h0001, 16'h0000},
    parameter logic [NREG-1:0]          REGION_WO    = 4'b1000,
    parameter int                       TIMEOUT      = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    input  logic                       m_read,
    input  logic                       m_write,
    input  logic                       m_instr,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_busy,
    output logic                       m_ready,
    output logic                       m_err,
    output logic [NREG:0]              s_sel,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic                       s_read,
    output logic                       s_write,
    output logic                       s_instr,
    input  logic [(NREG+1)*DATA_W-1:0] s_rdata,
    input  logic [NREG:0]              s_ready,
    output logic [NREG:0]              s_read_done
);

    bus_state_e        state_q;
    logic [NREG:0]     sel_q, done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              instr_q, write_q, skip_q;
    logic              rd_q, wr_q, ready_q, busy_q, err_q;

    logic [NREG:0]     sel_d;
    logic [ADDR_W-1:0] offset_d;
    logic              wo_d;
    logic [DATA_W-1:0] slave_data, resp_data_d;
    logic              slave_hit, tmo_hit, err_d, finish;

    mmio_addr_decode #(
        .ADDR_W       (ADDR_W),
        .NREG         (NREG),
        .REGION_BASE  (REGION_BASE),
        .REGION_LIMIT (REGION_LIMIT),
        .REGION_WO    (REGION_WO)
    ) u_decode (
        .addr_i   (m_addr),
        .instr_i  (m_instr),
        .sel_o    (sel_d),
        .offset_o (offset_d),
        .wo_o     (wo_d)
    );

    always_comb begin
        slave_data = '0;
        for (int j = 0; j <= NREG; j++) begin
            if (sel_q[j]) begin
                slave_data = slave_data | s_rdata[j*DATA_W +: DATA_W];
            end
        end
    end

    assign slave_hit = |(s_ready & sel_q);

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk) begin
        if (rst || state_q == ST_IDLE || state_q == ST_RESP) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == ST_ACCESS || state_q == ST_WAIT) && (tmo_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // A slave answering on the terminal-count cycle takes priority over the abort.
    assign err_d       = tmo_hit && !slave_hit && !skip_q;
    assign finish      = skip_q || slave_hit || tmo_hit;
    assign resp_data_d = skip_q ? '0 : (slave_hit ? slave_data : {DATA_W{ERR_FILL}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            done_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            instr_q <= 1'b0;
            write_q <= 1'b0;
            skip_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    done_q  <= '0;
                    err_q   <= 1'b0;
                    if (m_read || m_write) begin
                        state_q <= ST_ACCESS;
                        busy_q  <= 1'b1;
                        addr_q  <= offset_d;
                        wdata_q <= m_wdata;
                        instr_q <= m_instr;
                        write_q <= m_write;
                        skip_q  <= m_read && !m_write && wo_d;
                        if (m_write || !wo_d) begin
                            sel_q <= sel_d;
                            rd_q  <= !m_write;
                            wr_q  <= m_write;
                        end
                    end
                end
                ST_ACCESS, ST_WAIT: begin
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                    if (finish) begin
                        state_q <= ST_RESP;
                        busy_q  <= 1'b0;
                        sel_q   <= '0;
                        ready_q <= 1'b1;
                        err_q   <= err_d;
                        skip_q  <= 1'b0;
                        if (!write_q) begin
                            rdata_q <= resp_data_d;
                            done_q  <= slave_hit ? sel_q : '0;
                        end
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    done_q  <= '0;
                    err_q   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_rdata     = rdata_q;
    assign m_busy      = busy_q;
    assign m_ready     = ready_q;
`ifdef BUS_TIMEOUT_EN
    assign m_err       = err_q;
`else
    assign m_err       = 1'b0;
`endif
    assign s_sel       = sel_q;
    assign s_addr      = addr_q;
    assign s_wdata     = wdata_q;
    assign s_read      = rd_q;
    assign s_write     = wr_q;
    assign s_instr     = instr_q;
    assign s_read_done = done_q;

endmodule

// File: tb/tb_mmio_bus_switch.sv
// Scoreboard bench for mmio_bus_switch: directed transactions push expected
// slave accesses and master responses; monitors pop and compare.
module tb_mmio_bus_switch;

`ifdef BUS_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m_addr = '0, m_wdata = '0;
    logic        m_read = 1'b0, m_write = 1'b0, m_instr = 1'b0;
    logic [15:0] m_rdata;
    logic        m_busy, m_ready, m_err;
    logic [4:0]  s_sel, s_read_done;
    logic [15:0] s_addr, s_wdata;
    logic        s_read, s_write, s_instr;
    logic [79:0] s_rdata = {16'hD004, 16'hD003, 16'hD002, 16'hD001, 16'hD000};
    logic [4:0]  s_ready = '0;

    mmio_bus_switch #(
        .ADDR_W(16), .DATA_W(16), .NREG(4),
        .REGION_BASE ({16'h1000, 16'h0002, 16'h0001, 16'h0000}),
        .REGION_LIMIT({16'h4BFF, 16'h0002, 16'h0001, 16'h0000}),
        .REGION_WO(4'b1000), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read),
        .m_write(m_write), .m_instr(m_instr), .m_rdata(m_rdata), .m_busy(m_busy),
        .m_ready(m_ready), .m_err(m_err), .s_sel(s_sel), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_read(s_read), .s_write(s_write), .s_instr(s_instr),
        .s_rdata(s_rdata), .s_ready(s_ready), .s_read_done(s_read_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] rdata; logic err; logic [4:0] done; int lat; int start; } resp_t;
    typedef struct { logic [4:0] sel; logic [15:0] addr; logic [15:0] wdata; logic wr; logic instr; } acc_t;

    resp_t resp_q[$];
    acc_t  acc_q[$];
    int    checks = 0, errors = 0, cyc = 0, wait_cfg = 0, s_cnt = 0;
    bit    s_active = 0, prev_strobe = 0;
    logic [15:0] last_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: selected slave answers wait_cfg cycles after its strobe.
    always @(negedge clk) begin
        if (s_read || s_write) begin
            s_active = 1;
            s_cnt = wait_cfg;
        end else if (s_sel == '0) begin
            s_active = 0;
        end else if (s_cnt > 0) begin
            s_cnt--;
        end
        s_ready = (s_active && s_cnt == 0) ? s_sel : 5'b0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (s_read || s_write) begin
                checks++;
                if (prev_strobe) begin
                    errors++;
                    $display("FAIL strobe_len: strobe high two cycles, required one");
                end
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_strobe: sel=%b addr=%h, required no access", s_sel, s_addr);
                end else begin
                    acc_t x;
                    x = acc_q.pop_front();
                    if ({s_sel, s_addr, s_wdata, s_write, s_read, s_instr} !==
                        {x.sel, x.addr, x.wdata, x.wr, ~x.wr, x.instr}) begin
                        errors++;
                        $display("FAIL slave_access: sel=%b addr=%h wdata=%h wr=%b rd=%b instr=%b, required sel=%b addr=%h wdata=%h wr=%b rd=%b instr=%b",
                                 s_sel, s_addr, s_wdata, s_write, s_read, s_instr,
                                 x.sel, x.addr, x.wdata, x.wr, ~x.wr, x.instr);
                    end
                end
            end
            prev_strobe = s_read || s_write;
            if (m_ready) begin
                checks++;
                if (resp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_ready: m_ready with no transaction outstanding");
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    if ({m_rdata, m_err, s_read_done, m_busy} !== {r.rdata, r.err, r.done, 1'b0} ||
                        (cyc - r.start) != r.lat) begin
                        errors++;
                        $display("FAIL response: rdata=%h err=%b done=%b busy=%b lat=%0d, required rdata=%h err=%b done=%b busy=0 lat=%0d",
                                 m_rdata, m_err, s_read_done, m_busy, cyc - r.start,
                                 r.rdata, r.err, r.done, r.lat);
                    end
                end
            end else if (s_read_done != '0) begin
                checks++;
                errors++;
                $display("FAIL stray_read_done: %b without m_ready, required 00000", s_read_done);
            end
        end
    end

    function automatic logic [15:0] slave_val(input int idx);
        return 16'hD000 + 16'(idx);
    endfunction

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({m_rdata, m_busy, m_ready, m_err, s_sel, s_addr, s_wdata, s_read, s_write, s_instr, s_read_done} !== '0) begin
            errors++;
            $display("FAIL %s: rdata=%h busy=%b ready=%b err=%b sel=%b addr=%h wdata=%h rd=%b wr=%b instr=%b done=%b, required all zero",
                     name, m_rdata, m_busy, m_ready, m_err, s_sel, s_addr, s_wdata, s_read, s_write, s_instr, s_read_done);
        end
    endtask

    task automatic txn(input logic [15:0] a, input logic [15:0] d, input logic rd, input logic wr,
                       input logic ins, input int waits, input logic [4:0] esel, input logic [15:0] eaddr,
                       input logic wo, input logic tmo, input logic hold);
        resp_t r;
        acc_t  x;
        int    idx;
        bit    done_ok;
        idx = 0;
        for (int j = 0; j < 5; j++) if (esel[j]) idx = j;
        if (wr) begin
            r.rdata = last_rdata; r.done = '0; r.err = tmo; r.lat = tmo ? 1 + TMO : 2 + waits;
        end else if (wo) begin
            r.rdata = '0; r.done = '0; r.err = 0; r.lat = 2;
        end else if (tmo) begin
            r.rdata = 16'hFFFF; r.done = '0; r.err = 1; r.lat = 1 + TMO;
        end else begin
            r.rdata = slave_val(idx); r.done = esel; r.err = 0; r.lat = 2 + waits;
        end
        last_rdata = r.rdata;
        if (wr || !wo) begin
            x.sel = esel; x.addr = eaddr; x.wdata = d; x.wr = wr; x.instr = ins;
            acc_q.push_back(x);
        end
        wait_cfg = waits;
        @(negedge clk);
        r.start = cyc;
        resp_q.push_back(r);
        m_addr = a; m_wdata = d; m_read = rd; m_write = wr; m_instr = ins;
        @(posedge clk);
        #1;
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_access: m_busy=%b after request, required 1", m_busy);
        end
        if (hold) begin
            m_addr = 16'h0001; m_read = 1; m_write = 0; m_instr = 0;
        end else begin
            m_read = 0; m_write = 0; m_instr = 0;
        end
        done_ok = 0;
        for (int k = 0; k < 400 && !done_ok; k++) begin
            @(negedge clk);
            #1;
            if (resp_q.size() == 0) done_ok = 1;
        end
        m_read = 0; m_write = 0; m_instr = 0;
        if (!done_ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: no m_ready for addr %h, required one within 400 cycles", a);
            resp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        rst = 0;
        @(negedge clk);

        //   addr      data      rd wr in waits sel       s_addr    wo tmo hold
        txn(16'h0001, 16'h0000, 1, 0, 0, 0, 5'b00010, 16'h0000, 0, 0, 0);
        txn(16'h2000, 16'hBEEF, 0, 1, 0, 0, 5'b01000, 16'h1000, 0, 0, 0);
        txn(16'h2000, 16'h0000, 1, 0, 0, 0, 5'b00000, 16'h0000, 1, 0, 0);
        txn(16'h0001, 16'h0000, 1, 0, 1, 0, 5'b10000, 16'h0001, 0, 0, 0);
        txn(16'h8000, 16'h0000, 1, 0, 0, 5, 5'b10000, 16'h8000, 0, 0, 0);
        txn(16'h0000, 16'h1234, 1, 0, 0, 0, 5'b00001, 16'h0000, 0, 0, 0);
        txn(16'h0002, 16'h0000, 1, 0, 0, 2, 5'b00100, 16'h0000, 0, 0, 0);
        txn(16'h1000, 16'h5A5A, 0, 1, 0, 1, 5'b01000, 16'h0000, 0, 0, 0);
        txn(16'h4BFF, 16'h0000, 1, 0, 0, 0, 5'b00000, 16'h0000, 1, 0, 0);
        txn(16'h4C00, 16'h0000, 1, 0, 0, 0, 5'b10000, 16'h4C00, 0, 0, 0);
        txn(16'h0FFF, 16'h0000, 1, 0, 0, 1, 5'b10000, 16'h0FFF, 0, 0, 0);
        txn(16'h0003, 16'h0000, 1, 0, 0, 0, 5'b10000, 16'h0003, 0, 0, 0);
        txn(16'h0000, 16'hCAFE, 1, 1, 0, 0, 5'b00001, 16'h0000, 0, 0, 0);
        txn(16'h0002, 16'h0000, 1, 0, 0, 3, 5'b00100, 16'h0000, 0, 0, 1);

        // Reset in WAIT: strobe expected, response must never appear.
        begin
            acc_t x;
            x.sel = 5'b10000; x.addr = 16'h8000; x.wdata = 16'h0000; x.wr = 0; x.instr = 0;
            acc_q.push_back(x);
            wait_cfg = 1000;
            @(negedge clk);
            m_addr = 16'h8000; m_wdata = 16'h0000; m_read = 1;
            @(posedge clk);
            #1;
            m_read = 0;
            repeat (3) @(negedge clk);
            rst = 1;
            @(posedge clk);
            #1;
            check_idle_outputs("reset_mid_wait");
            rst = 0;
            last_rdata = '0;
            repeat (4) @(negedge clk);
            checks++;
            if (acc_q.size() != 0) begin
                errors++;
                $display("FAIL reset_strobe: %0d accesses not seen, required 0", acc_q.size());
                acc_q.delete();
            end
        end
        txn(16'h0001, 16'h0000, 1, 0, 0, 1, 5'b00010, 16'h0000, 0, 0, 0);

`ifdef BUS_TIMEOUT_EN
        txn(16'h8000, 16'h0000, 1, 0, 0, 1000, 5'b10000, 16'h8000, 0, 1, 0);
        txn(16'h8000, 16'h0000, 1, 0, 0, 7, 5'b10000, 16'h8000, 0, 0, 0);
        txn(16'h0002, 16'h0000, 1, 0, 0, 6, 5'b00100, 16'h0000, 0, 0, 0);
`endif

        repeat (5) @(negedge clk);
        checks++;
        if (resp_q.size() != 0 || acc_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses %0d accesses outstanding, required 0 0", resp_q.size(), acc_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
